// File: rtl/audiosystem_clkgen_pkg.sv
// rtl/audiosystem_clkgen_pkg.sv - shared constants, types and helpers for the clock-enable generator
package audiosystem_clkgen_pkg;

    localparam int DEF_ACC_W = 24;

    typedef logic [DEF_ACC_W-1:0] cfg_word_t;

    // Wide enough to hold the saturated value LOCK_CYCLES itself.
    function automatic int lock_cnt_w(input int lock_cycles);
        return $clog2(lock_cycles + 1);
    endfunction

endpackage

// File: rtl/audiosystem_clkgen_ch.sv
// rtl/audiosystem_clkgen_ch.sv - one enable channel; modulo-D counter, or phase accumulator with AUDIOSYSTEM_CLKGEN_FRAC_EN
module audiosystem_clkgen_ch
    import audiosystem_clkgen_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ACC_W-1:0] cfg,
    input  logic             run,
    output logic             ce,
    output logic             tgl
);

    // run is the value locked will take after this edge, so the first
    // locked cycle already carries the n=1 decision.
`ifdef AUDIOSYSTEM_CLKGEN_FRAC_EN
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic             carry;

    always_comb begin
        {carry, acc_next} = {1'b0, acc} + {1'b0, cfg};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            ce  <= 1'b0;
            tgl <= 1'b0;
        end else if (!run) begin
            acc <= '0;
            ce  <= 1'b0;
            tgl <= 1'b0;
        end else begin
            acc <= acc_next;
            ce  <= carry;
            tgl <= tgl ^ carry;
        end
    end
`else
    logic [ACC_W-1:0] cnt;
    logic [ACC_W:0]   cnt_inc;
    logic             hit;

    always_comb begin
        cnt_inc = {1'b0, cnt} + 1'b1;
        hit     = (cfg != '0) && (cnt_inc == {1'b0, cfg});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            ce  <= 1'b0;
            tgl <= 1'b0;
        end else if (!run) begin
            cnt <= '0;
            ce  <= 1'b0;
            tgl <= 1'b0;
        end else if (cfg == '0) begin
            ce  <= 1'b0;
        end else if (hit) begin
            cnt <= '0;
            ce  <= 1'b1;
            tgl <= ~tgl;
        end else begin
            cnt <= cnt_inc[ACC_W-1:0];
            ce  <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/audiosystem_clk_en_gen.sv
// rtl/audiosystem_clk_en_gen.sv - multi-channel clock-enable generator with lock sequencing; AUDIOSYSTEM_CLKGEN_FRAC_EN selects fractional channels
module audiosystem_clk_en_gen
    import audiosystem_clkgen_pkg::*;
#(
    parameter int                      NUM_CH      = 4,
    parameter int                      ACC_W       = DEF_ACC_W,
    parameter int                      LOCK_CYCLES = 1024,
    parameter logic [NUM_CH*ACC_W-1:0] INIT_CFG    = {NUM_CH{ACC_W'(2)}},
    localparam int                     CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_word,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] tgl,
    output logic              locked
);

    localparam int LCW = lock_cnt_w(LOCK_CYCLES);

    logic [LCW-1:0]          lock_cnt;
    logic [LCW-1:0]          lock_cnt_next;
    logic                    locked_next;
    logic                    accept;
    logic                    reconfig;
    logic [(1<<CH_W)-1:0]    ch_ok;
    logic [ACC_W-1:0]        cfg [NUM_CH];

    // Constant mask avoids a range compare that is trivially true for power-of-two NUM_CH.
    for (genvar k = 0; k < (1 << CH_W); k++) begin : g_ch_ok
        assign ch_ok[k] = (k < NUM_CH);
    end

    assign cfg_ready = locked;
    assign accept    = cfg_valid && locked;
    assign reconfig  = accept && ch_ok[cfg_ch];

    always_comb begin
        lock_cnt_next = lock_cnt;
        if (reconfig) begin
            lock_cnt_next = '0;
        end else if (lock_cnt != LCW'(LOCK_CYCLES)) begin
            lock_cnt_next = lock_cnt + 1'b1;
        end
        locked_next = (lock_cnt_next == LCW'(LOCK_CYCLES));
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else begin
            lock_cnt <= lock_cnt_next;
            locked   <= locked_next;
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cfg[i] <= INIT_CFG[i*ACC_W +: ACC_W];
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (reconfig && (cfg_ch == CH_W'(i))) begin
                    cfg[i] <= cfg_word;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        audiosystem_clkgen_ch #(
            .ACC_W (ACC_W)
        ) u_ch (
            .clk (refclk),
            .rst (rst),
            .cfg (cfg[g]),
            .run (locked_next),
            .ce  (ce[g]),
            .tgl (tgl[g])
        );
    end

endmodule

// File: tb/tb_audiosystem_clk_en_gen.sv
// tb/tb_audiosystem_clk_en_gen.sv - randomized self-checking bench against a closed-form strobe model
module tb_audiosystem_clk_en_gen;

    localparam int NUM_CH = 3;
    localparam int ACC_W  = 24;
    localparam int LOCK   = 16;
    localparam int OBS_W  = 2 * NUM_CH + 2;

`ifdef AUDIOSYSTEM_CLKGEN_FRAC_EN
    localparam logic [NUM_CH*ACC_W-1:0] INIT = {24'h3EEA21, 24'h000000, 24'h800000};
`else
    localparam logic [NUM_CH*ACC_W-1:0] INIT = {24'd3, 24'd0, 24'd2};
`endif

    logic              refclk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [1:0]        cfg_ch = '0;
    logic [ACC_W-1:0]  cfg_word = '0;
    logic [NUM_CH-1:0] ce;
    logic [NUM_CH-1:0] tgl;
    logic              locked;

    int checks = 0;
    int fails  = 0;
    int since;
    logic [ACC_W-1:0] mcfg [NUM_CH];

    audiosystem_clk_en_gen #(
        .NUM_CH      (NUM_CH),
        .ACC_W       (ACC_W),
        .LOCK_CYCLES (LOCK),
        .INIT_CFG    (INIT)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_word  (cfg_word),
        .ce        (ce),
        .tgl       (tgl),
        .locked    (locked)
    );

    always #5 refclk = ~refclk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Strobe k of a channel happens in the cycle where floor(n/D) (or floor(n*INC/2^W)) steps.
    function automatic longint strobes(int i, longint n);
        longint d;
        d = longint'(mcfg[i]);
`ifdef AUDIOSYSTEM_CLKGEN_FRAC_EN
        return (n * d) >> ACC_W;
`else
        return (d == 0) ? 0 : n / d;
`endif
    endfunction

    function automatic logic [OBS_W-1:0] expected();
        logic [NUM_CH-1:0] e_ce;
        logic [NUM_CH-1:0] e_tgl;
        longint n;
        e_ce  = '0;
        e_tgl = '0;
        if (since >= LOCK) begin
            n = since - LOCK + 1;
            for (int i = 0; i < NUM_CH; i++) begin
                e_ce[i]  = strobes(i, n) != strobes(i, n - 1);
                e_tgl[i] = strobes(i, n) % 2 == 1;
            end
        end
        return {since >= LOCK, since >= LOCK, e_ce, e_tgl};
    endfunction

    function automatic logic [ACC_W-1:0] rand_word();
`ifdef AUDIOSYSTEM_CLKGEN_FRAC_EN
        return ACC_W'($urandom);
`else
        return ACC_W'($urandom_range(0, 7));
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) mcfg[i] = INIT[i*ACC_W +: ACC_W];
        since = 0;
    endtask

    task automatic tick(output bit accepted);
        bit acc;
        acc = cfg_valid && (since >= LOCK);
        @(posedge refclk);
        accepted = acc;
        if (acc && (int'(cfg_ch) < NUM_CH)) begin
            mcfg[cfg_ch] = cfg_word;
            since = 0;
        end else begin
            since++;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({locked, cfg_ready, ce, tgl} !== '0) begin
            fails++;
            $display("FAIL reset_state: got %b required %b", {locked, cfg_ready, ce, tgl}, {OBS_W{1'b0}});
        end
        repeat (2) @(posedge refclk);
        @(negedge refclk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_lock();
        bit a;
        for (int c = 1; c <= LOCK + 4; c++) begin
            tick(a);
            checks++;
            if ({locked, cfg_ready, ce, tgl} !== expected()) begin
                fails++;
                $display("FAIL lock_seq edge %0d: got %b required %b", c, {locked, cfg_ready, ce, tgl}, expected());
            end
        end
    endtask

    task automatic test_patterns();
        bit a;
        for (int c = 0; c < 40; c++) begin
            tick(a);
            checks++;
            if ({locked, cfg_ready, ce, tgl} !== expected()) begin
                fails++;
                $display("FAIL init_pattern cycle %0d: got %b required %b", c, {locked, cfg_ready, ce, tgl}, expected());
            end
        end
    endtask

    task automatic test_reconfig_ch1();
        bit a;
        cfg_valid = 1'b1;
        cfg_ch    = 2'd1;
`ifdef AUDIOSYSTEM_CLKGEN_FRAC_EN
        cfg_word  = 24'h555555;
`else
        cfg_word  = 24'd5;
`endif
        tick(a);
        cfg_valid = 1'b0;
        checks++;
        if (locked !== 1'b0 || !a) begin
            fails++;
            $display("FAIL reconfig_accept: locked %b accepted %0d required locked 0 accepted 1", locked, a);
        end
        for (int c = 0; c < LOCK + 30; c++) begin
            tick(a);
            checks++;
            if ({locked, cfg_ready, ce, tgl} !== expected()) begin
                fails++;
                $display("FAIL reconfig_ch1 cycle %0d: got %b required %b", c, {locked, cfg_ready, ce, tgl}, expected());
            end
        end
    endtask

    task automatic test_out_of_range();
        bit a;
        cfg_valid = 1'b1;
        cfg_ch    = 2'(NUM_CH);
        cfg_word  = rand_word();
        tick(a);
        cfg_valid = 1'b0;
        checks++;
        if (locked !== 1'b1 || !a) begin
            fails++;
            $display("FAIL oor_handshake: locked %b accepted %0d required locked 1 accepted 1", locked, a);
        end
        for (int c = 0; c < 20; c++) begin
            tick(a);
            checks++;
            if ({locked, cfg_ready, ce, tgl} !== expected()) begin
                fails++;
                $display("FAIL oor_pattern cycle %0d: got %b required %b", c, {locked, cfg_ready, ce, tgl}, expected());
            end
        end
    endtask

    task automatic test_unlocked_request();
        bit a;
        int guard;
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_word  = rand_word();
        tick(a);
        cfg_ch    = 2'd2;
        cfg_word  = rand_word();
        a         = 1'b0;
        guard     = 0;
        while (!a && guard < 4 * LOCK) begin
            tick(a);
            guard++;
            checks++;
            if ({locked, cfg_ready, ce, tgl} !== expected()) begin
                fails++;
                $display("FAIL held_request cycle %0d: got %b required %b", guard, {locked, cfg_ready, ce, tgl}, expected());
            end
        end
        cfg_valid = 1'b0;
        checks++;
        if (!a || guard != LOCK + 1) begin
            fails++;
            $display("FAIL held_accept_time: accepted %0d after %0d edges required 1 after %0d", a, guard, LOCK + 1);
        end
        for (int c = 0; c < LOCK + 20; c++) begin
            tick(a);
            checks++;
            if ({locked, cfg_ready, ce, tgl} !== expected()) begin
                fails++;
                $display("FAIL after_held cycle %0d: got %b required %b", c, {locked, cfg_ready, ce, tgl}, expected());
            end
        end
    endtask

    task automatic test_random_reconfig();
        bit a;
        int guard;
        for (int k = 0; k < 8; k++) begin
            guard = 0;
            while (since < LOCK && guard < 2 * LOCK) begin
                tick(a);
                guard++;
            end
            cfg_valid = 1'b1;
            cfg_ch    = 2'($urandom_range(0, NUM_CH));
            cfg_word  = rand_word();
            tick(a);
            cfg_valid = 1'b0;
            for (int c = 0; c < LOCK + int'($urandom_range(10, 40)); c++) begin
                tick(a);
                checks++;
                if ({locked, cfg_ready, ce, tgl} !== expected()) begin
                    fails++;
                    $display("FAIL rand_reconfig %0d cycle %0d: got %b required %b", k, c, {locked, cfg_ready, ce, tgl}, expected());
                end
            end
        end
    endtask

    task automatic test_async_reset();
        bit a;
        repeat (7) tick(a);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({locked, cfg_ready, ce, tgl} !== '0) begin
            fails++;
            $display("FAIL async_reset: got %b required %b", {locked, cfg_ready, ce, tgl}, {OBS_W{1'b0}});
        end
        @(posedge refclk);
        @(negedge refclk);
        #2;
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < LOCK + 30; c++) begin
            tick(a);
            checks++;
            if ({locked, cfg_ready, ce, tgl} !== expected()) begin
                fails++;
                $display("FAIL post_reset cycle %0d: got %b required %b", c, {locked, cfg_ready, ce, tgl}, expected());
            end
        end
    endtask

`ifdef AUDIOSYSTEM_CLKGEN_FRAC_EN
    task automatic test_frac_rate();
        bit a;
        int cnt;
        longint lo;
        rst = 1'b1;
        @(negedge refclk);
        rst = 1'b0;
        model_reset();
        repeat (LOCK - 1) tick(a);
        cnt = 0;
        for (int c = 0; c < 100000; c++) begin
            tick(a);
            if (ce[2]) cnt++;
        end
        lo = (longint'(100000) * 64'h3EEA21) >> ACC_W;
        checks++;
        if (cnt < 24575 || cnt > 24577 || longint'(cnt) != lo) begin
            fails++;
            $display("FAIL frac_rate: got %0d strobes required %0d (24576 +/- 1)", cnt, lo);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_lock();
        test_patterns();
        test_reconfig_ch1();
        test_out_of_range();
        test_unlocked_request();
        test_random_reconfig();
        test_async_reset();
`ifdef AUDIOSYSTEM_CLKGEN_FRAC_EN
        test_frac_rate();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
